// File: rtl/epp_pkg.sv
// Shared EPP definitions: WR polarity, command op encodings, gpu register map, host FSM states.
// Used by the EPP host, the gpu responder and the benches that talk to either of them.
// Pure declarations; no logic, no latency, no flow control.
package epp_pkg;

    // EppWR polarity as seen on the pin.
    localparam logic EPP_WRITE = 1'b0;
    localparam logic EPP_READ  = 1'b1;

    // Command op encodings: bit 0 = read, bit 1 = data (vs address) strobe.
    localparam logic [1:0] OP_ADDR_WR = 2'd0;
    localparam logic [1:0] OP_ADDR_RD = 2'd1;
    localparam logic [1:0] OP_DATA_WR = 2'd2;
    localparam logic [1:0] OP_DATA_RD = 2'd3;

    // gpu register map end points (address byte written with an addr-write op).
    localparam logic [3:0] REG_X1_L   = 4'd0;
    localparam logic [3:0] REG_STATUS = 4'd15;

    // Host FSM states, kept as plain constants so older tools and benches can match them.
    typedef logic [2:0] epp_state_t;
    localparam epp_state_t ST_IDLE    = 3'd0;
    localparam epp_state_t ST_SETUP   = 3'd1;
    localparam epp_state_t ST_STROBE  = 3'd2;
    localparam epp_state_t ST_HOLD    = 3'd3;
    localparam epp_state_t ST_RECOVER = 3'd4;

    // Width of the shared setup/hold/timeout counter.
    localparam int EPP_CNT_W = 10;

    // True when the op reads from the responder (EppWR high during the strobe).
    function automatic logic op_is_read(input logic [1:0] op);
        return op[0];
    endfunction

    // True when the op uses the data strobe rather than the address strobe.
    function automatic logic op_is_data(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/epp_host_if.sv
// Local command/response port of the EPP host: one byte command in, one response pulse out.
// Command accepted on cmd_valid & cmd_ready; response is a single-cycle rsp_valid pulse.
// No back-pressure on the response side; the requester must take rsp_* when rsp_valid is high.
interface epp_host_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_wdata;

    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_timeout;

    // Requester side (bench, bridge logic).
    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_wdata,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_timeout
    );

    // EPP host side.
    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_wdata,
        output cmd_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_timeout
    );

endinterface

// File: rtl/epp_sync2.sv
// Two-flop synchroniser for signals arriving from the EPP pins (Wait, and the data bus on reads).
// Latency: 2 uclk cycles from pin to q.
// No flow control; bits are synchronised independently, so multi-bit values must be stable while sampled.
module epp_sync2 #(
    parameter int W = 1
) (
    input  logic         uclk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // First stage may go metastable; second stage gives it a full cycle to settle.
    always_ff @(posedge uclk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/epp_host.sv
// EPP initiator: turns one local byte command into one complete address/data EPP cycle on the pins.
// Latency: accept -> rsp_valid = 1 + SETUP + strobe time + HOLD + Wait-release time (cycles of uclk).
// cmd_ready only in IDLE, so one command is in flight at a time; rsp_valid is a pulse with no back-pressure.
module epp_host
    import epp_pkg::*;
#(
    parameter int SETUP_CYCLES   = 2,
    parameter int HOLD_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       uclk,
    input  logic       rst_n,
    epp_host_if.slave  bus,
    inout  wire  [7:0] EppDB,
    output logic       EppAstb,
    output logic       EppDstb,
    output logic       EppWR,
    input  logic       EppWait
);

    // Counter compare points; all phases count from 0 on entry.
    localparam logic [EPP_CNT_W-1:0] SETUP_LAST   = EPP_CNT_W'(SETUP_CYCLES - 1);
    localparam logic [EPP_CNT_W-1:0] HOLD_LAST    = EPP_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [EPP_CNT_W-1:0] TIMEOUT_LAST = EPP_CNT_W'(TIMEOUT_CYCLES - 1);

    epp_state_t           state;
    logic [EPP_CNT_W-1:0] cnt;
    logic [1:0]           op_q;
    logic [7:0]           wdata_q;
    logic [7:0]           rd_q;
    logic                 db_oe;
    logic                 stale;
    logic                 ready_en;
    logic                 wait_s;
    logic [7:0]           db_s;

    // Wait comes from another board with no clock relationship.
    epp_sync2 #(.W(1)) u_sync_wait (
        .uclk  (uclk),
        .rst_n (rst_n),
        .d     (EppWait),
        .q     (wait_s)
    );

    // Read data is only sampled once wait_s is seen high, by which time the
    // responder has held the bus stable for at least two cycles.
    epp_sync2 #(.W(8)) u_sync_db (
        .uclk  (uclk),
        .rst_n (rst_n),
        .d     (EppDB),
        .q     (db_s)
    );

    // Host drives the bus only for write ops, from accept until the end of HOLD.
    assign EppDB = db_oe ? wdata_q : 8'bz;

    // ready_en keeps cmd_ready low until the first edge after reset release.
    assign bus.cmd_ready = ready_en && (state == ST_IDLE);

    // One EPP cycle per accepted command; all pin outputs are registered so
    // reset forces the strobes high and floats the bus without waiting for a clock.
    always_ff @(posedge uclk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            op_q            <= OP_ADDR_WR;
            wdata_q         <= '0;
            rd_q            <= '0;
            db_oe           <= 1'b0;
            stale           <= 1'b0;
            ready_en        <= 1'b0;
            EppAstb         <= 1'b1;
            EppDstb         <= 1'b1;
            EppWR           <= EPP_READ;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            ready_en      <= 1'b1;
            bus.rsp_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        op_q    <= bus.cmd_op;
                        wdata_q <= bus.cmd_wdata;
                        EppWR   <= op_is_read(bus.cmd_op);
                        db_oe   <= !op_is_read(bus.cmd_op);
                        cnt     <= '0;
                        state   <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        if (op_is_data(op_q)) begin
                            EppDstb <= 1'b0;
                        end else begin
                            EppAstb <= 1'b0;
                        end
                        // A Wait still high here belongs to nobody; skip it
                        // until the responder has been seen to drop it.
                        stale <= wait_s;
                        cnt   <= '0;
                        state <= ST_STROBE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_STROBE: begin
                    if (cnt == TIMEOUT_LAST) begin
                        EppAstb         <= 1'b1;
                        EppDstb         <= 1'b1;
                        db_oe           <= 1'b0;
                        EppWR           <= EPP_READ;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_timeout <= 1'b1;
                        bus.rsp_rdata   <= '0;
                        state           <= ST_IDLE;
                    end else if (stale) begin
                        if (!wait_s) begin
                            stale <= 1'b0;
                        end
                        cnt <= cnt + 1'b1;
                    end else if (wait_s) begin
                        rd_q    <= op_is_read(op_q) ? db_s : 8'h00;
                        EppAstb <= 1'b1;
                        EppDstb <= 1'b1;
                        cnt     <= '0;
                        state   <= ST_HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        db_oe <= 1'b0;
                        EppWR <= EPP_READ;
                        cnt   <= '0;
                        state <= ST_RECOVER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RECOVER: begin
                    // Holding here until Wait drops guarantees the next strobe
                    // cannot be mistaken for completed by the previous Wait.
                    if (cnt == TIMEOUT_LAST) begin
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_timeout <= 1'b1;
                        bus.rsp_rdata   <= '0;
                        state           <= ST_IDLE;
                    end else if (!wait_s) begin
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_timeout <= 1'b0;
                        bus.rsp_rdata   <= rd_q;
                        state           <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    EppAstb <= 1'b1;
                    EppDstb <= 1'b1;
                    db_oe   <= 1'b0;
                    EppWR   <= EPP_READ;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_epp_host.sv
`timescale 1ns/1ps
module tb_epp_host;
    import epp_pkg::*;

    localparam int SETUP = 2;
    localparam int HOLD  = 1;
    localparam int TMO   = 1023;

    logic uclk;
    logic rst_n;
    logic EppAstb, EppDstb, EppWR, EppWait;
    wire  [7:0] EppDB;
    logic [7:0] resp_db;
    logic       resp_drv;

    epp_host_if bus();

    assign EppDB = resp_drv ? resp_db : 8'bz;

    epp_host #(
        .SETUP_CYCLES   (SETUP),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .uclk    (uclk),
        .rst_n   (rst_n),
        .bus     (bus),
        .EppDB   (EppDB),
        .EppAstb (EppAstb),
        .EppDstb (EppDstb),
        .EppWR   (EppWR),
        .EppWait (EppWait)
    );

    initial uclk = 1'b0;
    always #5 uclk = ~uclk;

    int cyc = 0;
    always @(posedge uclk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- responder: behaves like the gpu register file ----------------
    bit         resp_en;
    int         resp_k, resp_d;
    logic [7:0] g_addr;
    logic [7:0] g_regs [16];
    bit         rs_a, rs_rd;

    initial begin : responder
        EppWait  = 1'b0;
        resp_drv = 1'b0;
        resp_db  = 8'h00;
        g_addr   = 8'h00;
        for (int i = 0; i < 16; i++) g_regs[i] = 8'h00;
        forever begin
            @(posedge uclk); #1;
            if (resp_en && rst_n && (!EppAstb || !EppDstb)) begin
                rs_a  = !EppAstb;
                rs_rd = EppWR;
                for (int i = 0; i < resp_k; i++) begin @(posedge uclk); #1; end
                if (rs_rd) begin
                    resp_db  = rs_a ? g_addr : g_regs[g_addr[3:0]];
                    resp_drv = 1'b1;
                end else if (rs_a) begin
                    g_addr = EppDB;
                end else begin
                    g_regs[g_addr[3:0]] = EppDB;
                end
                EppWait = 1'b1;
                for (int g = 0; g < 4000 && (!EppAstb || !EppDstb); g++) begin @(posedge uclk); #1; end
                for (int i = 0; i < resp_d; i++) begin @(posedge uclk); #1; end
                EppWait  = 1'b0;
                resp_drv = 1'b0;
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    logic [7:0] m_addr;
    logic [7:0] m_regs [16];

    // Issue one command, watch the pins until the response, check everything.
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] wd, input bit keep_valid,
                          input logic [1:0] nop, input logic [7:0] nwd, input bit exp_tmo,
                          output logic [7:0] rdata);
        int   acc, fall, rise, wr_rise, lows, wfall, rsp_cyc, w;
        bit   got, seen_fall, was_a, both_low, wr_bad, db_bad, early_fall, wait_hi, w_prev;
        logic tmo;
        logic [7:0] exp_rd;

        exp_rd = 8'h00;
        if (op == OP_ADDR_RD) exp_rd = m_addr;
        else if (op == OP_DATA_RD) exp_rd = m_regs[m_addr[3:0]];

        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_wdata = wd;
        w = 0;
        while (!bus.cmd_ready && w < 50) begin @(negedge uclk); w++; end
        check("cmd_accept", {31'd0, bus.cmd_ready}, 32'd1);
        acc = cyc + 1;
        @(posedge uclk); #1;
        if (keep_valid) begin
            bus.cmd_op    = nop;
            bus.cmd_wdata = nwd;
        end else begin
            bus.cmd_valid = 1'b0;
        end

        got = 0; seen_fall = 0; was_a = 0; both_low = 0; wr_bad = 0; db_bad = 0;
        early_fall = 0; wait_hi = 0; w_prev = EppWait; tmo = 1'b0; rdata = 8'h00;
        fall = -1; rise = -1; wr_rise = -1; lows = 0; wfall = -1; rsp_cyc = -1;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge uclk);
            if (!EppAstb && !EppDstb) both_low = 1;
            if (!EppAstb || !EppDstb) begin
                if (!seen_fall) begin
                    seen_fall = 1; fall = cyc; was_a = !EppAstb;
                    if (w_prev) early_fall = 1;
                end
                lows++;
                if (EppWR !== op[0]) wr_bad = 1;
                if (!op[0] && EppDB !== wd) db_bad = 1;
                if (op[0] && resp_drv && EppDB !== resp_db) db_bad = 1;
            end else if (seen_fall && rise < 0) begin
                rise = cyc;
            end
            if (rise >= 0 && wr_rise < 0 && EppWR) wr_rise = cyc;
            if (EppWait) wait_hi = 1;
            if (wait_hi && !EppWait && wfall < 0) wfall = cyc;
            w_prev = EppWait;
            if (bus.rsp_valid) begin
                got = 1; rsp_cyc = cyc; rdata = bus.rsp_rdata; tmo = bus.rsp_timeout;
            end
        end

        check("rsp_seen", {31'd0, got}, 32'd1);
        if (got) begin
            check("strobe_fell", {31'd0, seen_fall}, 32'd1);
            check("strobe_select", {31'd0, was_a}, {31'd0, (op[1] == 1'b0)});
            check("setup_cycles", fall - acc, SETUP);
            check("strobe_overlap", {31'd0, both_low}, 32'd0);
            check("wr_level", {31'd0, wr_bad}, 32'd0);
            check("db_value", {31'd0, db_bad}, 32'd0);
            check("rsp_timeout", {31'd0, tmo}, {31'd0, exp_tmo});
            if (exp_tmo) begin
                check("tmo_strobe_len", lows, TMO);
                check("tmo_rdata", {24'd0, rdata}, 32'd0);
                check("tmo_rsp_at_release", rsp_cyc, rise);
            end else begin
                check("rdata_model", {24'd0, rdata}, {24'd0, exp_rd});
                check("strobe_after_wait_low", {31'd0, early_fall}, 32'd0);
                if (!op[0]) check("hold_cycles", wr_rise - rise, HOLD);
                check("rsp_after_wait_drop", {31'd0, (rsp_cyc >= wfall + 2)}, 32'd1);
                if (op == OP_ADDR_WR) m_addr = wd;
                if (op == OP_DATA_WR) m_regs[m_addr[3:0]] = wd;
            end
            if (!keep_valid) begin
                @(negedge uclk);
                check("rsp_pulse_1cyc", {31'd0, bus.rsp_valid}, 32'd0);
            end
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] wd;
        int         k;
        int         d;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl [10];
    logic [7:0] rd;
    bit         saw_rsp;

    initial begin : watchdog
        #700000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_wdata = 8'h00;
        resp_en       = 1'b1;
        resp_k        = 0;
        resp_d        = 0;
        m_addr        = 8'h00;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;

        // Reset values
        repeat (3) @(negedge uclk);
        check("rst_astb", {31'd0, EppAstb}, 32'd1);
        check("rst_dstb", {31'd0, EppDstb}, 32'd1);
        check("rst_wr", {31'd0, EppWR}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
        check("rst_rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd0);
        rst_n = 1'b1;
        @(negedge uclk);
        check("ready_after_release", {31'd0, bus.cmd_ready}, 32'd1);

        // Directed table against the gpu-like responder
        tbl[0] = '{OP_ADDR_WR, 8'h0E, 3, 1, 8'h00};
        tbl[1] = '{OP_DATA_WR, 8'hA5, 0, 0, 8'h00};
        tbl[2] = '{OP_ADDR_RD, 8'hFF, 2, 2, 8'h0E};
        tbl[3] = '{OP_DATA_RD, 8'h00, 1, 3, 8'hA5};
        tbl[4] = '{OP_ADDR_WR, 8'h00, 0, 2, 8'h00};
        tbl[5] = '{OP_DATA_WR, 8'h5A, 4, 0, 8'h00};
        tbl[6] = '{OP_DATA_RD, 8'hA5, 2, 1, 8'h5A};
        tbl[7] = '{OP_ADDR_WR, 8'h0E, 1, 1, 8'h00};
        tbl[8] = '{OP_DATA_RD, 8'h3C, 0, 4, 8'hA5};
        tbl[9] = '{OP_ADDR_RD, 8'h00, 5, 0, 8'h0E};
        for (int t = 0; t < 10; t++) begin
            resp_k = tbl[t].k;
            resp_d = tbl[t].d;
            do_cmd(tbl[t].op, tbl[t].wd, 1'b0, 2'd0, 8'h00, 1'b0, rd);
            check($sformatf("table_rdata_%0d", t), {24'd0, rd}, {24'd0, tbl[t].exp});
        end

        // Wait never asserted: strobe must time out after exactly TMO cycles
        resp_en = 1'b0;
        do_cmd(OP_DATA_WR, 8'h33, 1'b0, 2'd0, 8'h00, 1'b1, rd);
        resp_en = 1'b1;

        // cmd_valid held across two writes; slow Wait release
        resp_k = 1;
        resp_d = 6;
        do_cmd(OP_DATA_WR, 8'h11, 1'b1, OP_DATA_WR, 8'h22, 1'b0, rd);
        do_cmd(OP_DATA_WR, 8'h22, 1'b0, 2'd0, 8'h00, 1'b0, rd);
        do_cmd(OP_DATA_RD, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, rd);
        check("b2b_second_write", {24'd0, rd}, 32'h22);

        // Randomised traffic against the model
        for (int r = 0; r < 60; r++) begin
            logic [1:0] op;
            logic [7:0] wd;
            op     = 2'($urandom_range(0, 3));
            wd     = 8'($urandom_range(0, 255));
            resp_k = $urandom_range(0, 5);
            resp_d = $urandom_range(0, 5);
            do_cmd(op, wd, 1'b0, 2'd0, 8'h00, 1'b0, rd);
        end

        // Reset in the middle of a data strobe
        resp_en       = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_DATA_WR;
        bus.cmd_wdata = 8'h77;
        for (int n = 0; n < 20 && EppDstb; n++) @(negedge uclk);
        check("midrst_strobe_low", {31'd0, EppDstb}, 32'd0);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge uclk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_dstb_async", {31'd0, EppDstb}, 32'd1);
        check("midrst_astb_async", {31'd0, EppAstb}, 32'd1);
        check("midrst_wr_async", {31'd0, EppWR}, 32'd1);
        saw_rsp = 0;
        repeat (3) begin
            @(negedge uclk);
            if (bus.rsp_valid) saw_rsp = 1;
        end
        rst_n = 1'b1;
        @(negedge uclk);
        check("midrst_ready_after_release", {31'd0, bus.cmd_ready}, 32'd1);
        repeat (4) begin
            if (bus.rsp_valid) saw_rsp = 1;
            @(negedge uclk);
        end
        check("midrst_no_rsp", {31'd0, saw_rsp}, 32'd0);
        check("midrst_strobes_idle", {30'd0, EppAstb, EppDstb}, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
